// File: rtl/sar_convertidor.sv
// sar_convertidor: successive-approximation controller for the 5-bit
// magnitude comparator. Drives trial codes on dac_o, reads the decision back
// on cmp_i and resolves the unknown level MSB first, one bit per step.
module sar_convertidor #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] dac_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRIAL = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] dac_q,    dac_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [IW-1:0]    idx_dec_s;

  assign idx_dec_s = idx_q - IDX_ONE;

  // Next-state logic: start handling, per-bit settle/decide, done strobe.
  always_comb begin
    state_d  = state_q;
    dac_d    = dac_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        dac_d  = {WIDTH{1'b0}};
        busy_d = 1'b0;
        if (start_i) begin
          state_d = S_TRIAL;
          dac_d   = MSB_ONLY;
          busy_d  = 1'b1;
          idx_d   = IDX_TOP;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIAL: begin
        if (cnt_q == CNT_LAST) begin
          // cmp_i=1 means the trial overshoots the level: drop this bit.
          if (cmp_i) begin
            dac_d[idx_q] = 1'b0;
          end else begin
            dac_d[idx_q] = 1'b1;
          end
          cnt_d = {CW{1'b0}};
          if (idx_q == {IW{1'b0}}) begin
            state_d  = S_DONE;
            result_d = dac_d;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            idx_d    = IDX_TOP;
          end else begin
            idx_d            = idx_dec_s;
            dac_d[idx_dec_s] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        dac_d   = {WIDTH{1'b0}};
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        dac_d   = {WIDTH{1'b0}};
        busy_d  = 1'b0;
        idx_d   = IDX_TOP;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dac_q    <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      idx_q    <= IDX_TOP;
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dac_o    = dac_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
